conv_freq_mac: RTL and testbench

- Frequency-domain multiply-accumulate stage between convLayerFFT and convLayerIFFT.
- Per accepted input, multiplies the 4x4x4 complex image-tile spectrum element-wise by a matching 4x4x4 kernel spectrum.
- Accumulates over N_CH input channels, then presents the summed spectrum with a one-cycle-early `next_out` pulse that drives convLayerIFFT.next directly.

---
 rtl/conv_freq_mac_pkg.sv | 23 ++
 rtl/conv_freq_mac_cmplx_mult_pipe.sv | 58 +++++
 rtl/conv_freq_mac.sv | 120 ++++++++++++
 tb/tb_conv_freq_mac.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_freq_mac_pkg.sv
// Shared types and helpers for the frequency-domain multiply-accumulate stage.
// sat32 is only referenced when CONV_FREQ_MAC_SAT_EN is defined.
package conv_freq_mac_pkg;

    localparam int TILE_DIM      = 4;
    localparam int FRAC_BITS_DEF = 16;
    localparam int CH_W          = 8;

    typedef struct packed {
        logic signed [31:0] r;
        logic signed [31:0] i;
    } complex_t;

    typedef complex_t [0:TILE_DIM-1][0:TILE_DIM-1][0:TILE_DIM-1] tile_t;

    // Clamp a wide signed value into the signed 32-bit range.
    function automatic logic signed [31:0] sat32(input logic signed [64:0] x);
        if (x > 65'sh0_7FFF_FFFF)  return 32'sh7FFF_FFFF;
        if (x < -65'sh0_8000_0000) return 32'sh8000_0000;
        return x[31:0];
    endfunction

endpackage

// File: rtl/conv_freq_mac_cmplx_mult_pipe.sv
// One tile element: stage A operand capture, stage B registered partial products,
// and the combinational rescale. Saturates instead of wrapping under CONV_FREQ_MAC_SAT_EN.
module conv_freq_mac_cmplx_mult_pipe
    import conv_freq_mac_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  complex_t in_elem,
    input  complex_t k_elem,
    output complex_t prod
);

    complex_t           a_in_q, a_in_d, a_k_q, a_k_d;
    logic signed [63:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d, ir_q, ir_d;

    function automatic logic signed [31:0] scale(input logic signed [64:0] x);
`ifdef CONV_FREQ_MAC_SAT_EN
        return sat32(x >>> FRAC_BITS);
`else
        return 32'(x >>> FRAC_BITS);
`endif
    endfunction

    always_comb begin
        a_in_d = load ? in_elem : a_in_q;
        a_k_d  = load ? k_elem  : a_k_q;
        rr_d   = $signed(a_in_q.r) * $signed(a_k_q.r);
        ii_d   = $signed(a_in_q.i) * $signed(a_k_q.i);
        ri_d   = $signed(a_in_q.r) * $signed(a_k_q.i);
        ir_d   = $signed(a_in_q.i) * $signed(a_k_q.r);
        // Sign-extend to 65 bits so the sum/difference of two products cannot overflow.
        prod.r = scale({rr_q[63], rr_q} - {ii_q[63], ii_q});
        prod.i = scale({ri_q[63], ri_q} + {ir_q[63], ir_q});
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_in_q <= '0;
            a_k_q  <= '0;
            rr_q   <= '0;
            ii_q   <= '0;
            ri_q   <= '0;
            ir_q   <= '0;
        end else begin
            a_in_q <= a_in_d;
            a_k_q  <= a_k_d;
            rr_q   <= rr_d;
            ii_q   <= ii_d;
            ri_q   <= ri_d;
            ir_q   <= ir_d;
        end
    end

endmodule

// File: rtl/conv_freq_mac.sv
// Frequency-domain MAC: element-wise tile x kernel products summed over N_CH channels.
// Define CONV_FREQ_MAC_SAT_EN to saturate products and sums instead of wrapping.
module conv_freq_mac
    import conv_freq_mac_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  next,
    input  tile_t in,
    input  tile_t kernel,
    output logic  next_out,
    output tile_t out,
    output logic  busy
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic            next_q, next_d;
    logic [CH_W-1:0] cnt_q, cnt_d;
    logic            valid_a_q, valid_a_d, valid_b_q, valid_b_d;
    logic [CH_W-1:0] ch_a_q, ch_a_d, ch_b_q, ch_b_d;
    logic            last_ch;
    complex_t        prod   [0:TILE_DIM-1][0:TILE_DIM-1][0:TILE_DIM-1];
    complex_t        acc_q  [0:TILE_DIM-1][0:TILE_DIM-1][0:TILE_DIM-1];
    complex_t        acc_d  [0:TILE_DIM-1][0:TILE_DIM-1][0:TILE_DIM-1];
    tile_t           out_q, out_d;

    for (genvar x = 0; x < TILE_DIM; x++) begin : g_x
        for (genvar y = 0; y < TILE_DIM; y++) begin : g_y
            for (genvar z = 0; z < TILE_DIM; z++) begin : g_z
                conv_freq_mac_cmplx_mult_pipe #(.FRAC_BITS(FRAC_BITS)) u_pipe (
                    .clk     (clk),
                    .reset   (reset),
                    .load    (next_q),
                    .in_elem (in[x][y][z]),
                    .k_elem  (kernel[x][y][z]),
                    .prod    (prod[x][y][z])
                );
            end
        end
    end

    function automatic complex_t cadd(input complex_t a, input complex_t b);
        complex_t s;
`ifdef CONV_FREQ_MAC_SAT_EN
        s.r = sat32(65'(a.r) + 65'(b.r));
        s.i = sat32(65'(a.i) + 65'(b.i));
`else
        s.r = a.r + b.r;
        s.i = a.i + b.i;
`endif
        return s;
    endfunction

    always_comb begin
        complex_t sum;
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        sum       = '0;
        next_d    = next;
        cnt_d     = cnt_q;
        ch_a_d    = ch_a_q;
        valid_a_d = next_q;
        valid_b_d = valid_a_q;
        ch_b_d    = ch_a_q;
        acc_d     = acc_q;
        out_d     = out_q;
        if (next_q) begin
            ch_a_d = cnt_q;
            cnt_d  = (cnt_q == LAST_CH) ? '0 : cnt_q + 1'b1;
        end
        last_ch = valid_b_q && (ch_b_q == LAST_CH);
        for (int x = 0; x < TILE_DIM; x++) begin
            for (int y = 0; y < TILE_DIM; y++) begin
                for (int z = 0; z < TILE_DIM; z++) begin
                    // Channel 0 starts a fresh sum, so groups can run back to back.
                    sum = cadd((ch_b_q == '0) ? '0 : acc_q[x][y][z], prod[x][y][z]);
                    if (valid_b_q) begin
                        if (last_ch) begin
                            out_d[x][y][z] = sum;
                            acc_d[x][y][z] = '0;
                        end else begin
                            acc_d[x][y][z] = sum;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_q    <= 1'b0;
            cnt_q     <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            ch_a_q    <= '0;
            ch_b_q    <= '0;
            // NOTE: the accumulator array is reset explicitly; a partial sum must not survive reset.
            acc_q     <= '{default: '0};
            out_q     <= '0;
        end else begin
            next_q    <= next_d;
            cnt_q     <= cnt_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            ch_a_q    <= ch_a_d;
            ch_b_q    <= ch_b_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
        end
    end

    assign next_out = last_ch;
    assign out      = out_q;
    assign busy     = (cnt_q != '0) || next_q || valid_a_q || valid_b_q;

endmodule

// File: tb/tb_conv_freq_mac.sv
// Directed bench for conv_freq_mac with N_CH = 4, 1 and 2 instances on shared stimulus.
// Overflow expectation follows CONV_FREQ_MAC_SAT_EN when the bench is built with it.
module tb_conv_freq_mac;
    import conv_freq_mac_pkg::*;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] HALF = 32'h0000_8000;

    logic  clk = 1'b0;
    logic  reset;
    logic  next;
    tile_t in_t, k_t;
    logic  u4_next_out, u1_next_out, u2_next_out;
    logic  u4_busy, u1_busy, u2_busy;
    tile_t u4_out, u1_out, u2_out;
    int    n_cmp = 0;
    int    n_mis = 0;

    always #5 clk = ~clk;

    conv_freq_mac #(.N_CH(4)) u4 (.clk(clk), .reset(reset), .next(next), .in(in_t), .kernel(k_t),
                                  .next_out(u4_next_out), .out(u4_out), .busy(u4_busy));
    conv_freq_mac #(.N_CH(1)) u1 (.clk(clk), .reset(reset), .next(next), .in(in_t), .kernel(k_t),
                                  .next_out(u1_next_out), .out(u1_out), .busy(u1_busy));
    conv_freq_mac #(.N_CH(2)) u2 (.clk(clk), .reset(reset), .next(next), .in(in_t), .kernel(k_t),
                                  .next_out(u2_next_out), .out(u2_out), .busy(u2_busy));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares the first disagreeing element (or element 0) against the uniform expectation.
    task automatic chk_tile(input string tag, input tile_t t, input logic [31:0] er, input logic [31:0] ei);
        complex_t pick;
        bit found = 1'b0;
        pick = t[0][0][0];
        for (int x = 0; x < TILE_DIM; x++)
            for (int y = 0; y < TILE_DIM; y++)
                for (int z = 0; z < TILE_DIM; z++)
                    if (!found && t[x][y][z] !== {er, ei}) begin
                        pick  = t[x][y][z];
                        found = 1'b1;
                    end
        chk(tag, pick, {er, ei});
    endtask

    task automatic set_tiles(input logic [31:0] ir, input logic [31:0] ii,
                             input logic [31:0] kr, input logic [31:0] ki);
        for (int x = 0; x < TILE_DIM; x++)
            for (int y = 0; y < TILE_DIM; y++)
                for (int z = 0; z < TILE_DIM; z++) begin
                    in_t[x][y][z] = {ir, ii};
                    k_t[x][y][z]  = {kr, ki};
                end
    endtask

    task automatic tick(input bit nx);
        @(negedge clk);
        next = nx;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        next  = 1'b0;
        set_tiles(0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        next  = 1'b0;
        set_tiles(0, 0, 0, 0);
        #12;
        chk_tile("reset_out", u4_out, 32'h0, 32'h0);
        chk("reset_next_out", u4_next_out, 0);
        chk("reset_busy", u4_busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single group, N_CH=4: 1.0 x 2.0 summed four times = 8.0.
        for (int c = 0; c <= 7; c++) begin
            tick(c <= 3);
            if (c >= 1 && c <= 4) set_tiles(ONE, 0, 32'h0002_0000, 0);
            else set_tiles(0, 0, 0, 0);
            if (c == 2) chk("t1_busy_mid", u4_busy, 1);
            if (c == 5) chk("t1_next_out_early", u4_next_out, 0);
            if (c == 6) chk("t1_next_out", u4_next_out, 1);
            if (c == 7) begin
                chk_tile("t1_out", u4_out, 32'h0008_0000, 32'h0);
                chk("t1_busy_idle", u4_busy, 0);
            end
        end

        // N_CH=1 complex products: (1+2j)(3+4j) = -5+10j, then j(3+4j) = -4+3j.
        for (int c = 0; c <= 5; c++) begin
            tick(c <= 1);
            if (c == 1) set_tiles(ONE, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
            else if (c == 2) set_tiles(0, ONE, 32'h0003_0000, 32'h0004_0000);
            else set_tiles(0, 0, 0, 0);
            if (c == 2) chk("t2_next_out_early", u1_next_out, 0);
            if (c == 3) chk("t2_next_out_a", u1_next_out, 1);
            if (c == 4) begin
                chk("t2_next_out_b", u1_next_out, 1);
                chk_tile("t2_out_a", u1_out, 32'hFFFB_0000, 32'h000A_0000);
            end
            if (c == 5) begin
                chk("t2_next_out_done", u1_next_out, 0);
                chk_tile("t2_out_b", u1_out, 32'hFFFC_0000, 32'h0003_0000);
            end
        end

        // Back-to-back groups with no gap: 4 x 1.0 then 4 x 0.5.
        apply_reset();
        for (int c = 0; c <= 11; c++) begin
            tick(c <= 7);
            if (c >= 1 && c <= 4) set_tiles(ONE, 0, ONE, 0);
            else if (c >= 5 && c <= 8) set_tiles(HALF, 0, ONE, 0);
            else set_tiles(0, 0, 0, 0);
            if (c == 6) chk("t3_next_out_a", u4_next_out, 1);
            if (c == 7) begin
                chk("t3_next_out_gap", u4_next_out, 0);
                chk_tile("t3_out_a", u4_out, 32'h0004_0000, 32'h0);
            end
            if (c == 9) chk("t3_next_out_gap2", u4_next_out, 0);
            if (c == 10) begin
                chk("t3_next_out_b", u4_next_out, 1);
                chk_tile("t3_out_hold", u4_out, 32'h0004_0000, 32'h0);
            end
            if (c == 11) chk_tile("t3_out_b", u4_out, 32'h0002_0000, 32'h0);
        end

        // Async reset after two of four channels, then a full group of 1.0 x 1.0.
        for (int c = 0; c <= 4; c++) begin
            tick(c <= 1);
            if (c >= 1 && c <= 2) set_tiles(ONE, 0, ONE, 0);
            else set_tiles(0, 0, 0, 0);
            if (c == 4) begin
                chk("t4_busy_before", u4_busy, 1);
                #2 reset = 1'b1;
                #1;
                chk("t4_busy_in_reset", u4_busy, 0);
                chk_tile("t4_out_cleared", u4_out, 32'h0, 32'h0);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            tick(c <= 3);
            if (c >= 1 && c <= 4) set_tiles(ONE, 0, ONE, 0);
            else set_tiles(0, 0, 0, 0);
            if (c == 6) chk("t4_next_out", u4_next_out, 1);
            if (c == 7) chk_tile("t4_out", u4_out, 32'h0004_0000, 32'h0);
        end

        // Overflow, N_CH=2: 0x7FFF0000 x 1.0 twice.
        apply_reset();
        for (int c = 0; c <= 5; c++) begin
            tick(c <= 1);
            if (c >= 1 && c <= 2) set_tiles(32'h7FFF_0000, 0, ONE, 0);
            else set_tiles(0, 0, 0, 0);
            if (c == 4) chk("t5_next_out", u2_next_out, 1);
`ifdef CONV_FREQ_MAC_SAT_EN
            if (c == 5) chk_tile("t5_out_sat", u2_out, 32'h7FFF_FFFF, 32'h0);
`else
            if (c == 5) chk_tile("t5_out_wrap", u2_out, 32'hFFFE_0000, 32'h0);
`endif
        end

        // Gapped input every third cycle: 4 x (3.0 x 1.0), then 4 x (1.0 x 0.25).
        apply_reset();
        for (int c = 0; c <= 26; c++) begin
            tick((c % 3 == 0) && c <= 21);
            if (c % 3 == 1 && c <= 10) set_tiles(32'h0003_0000, 0, ONE, 0);
            else if (c % 3 == 1 && c <= 22) set_tiles(ONE, 0, 32'h0000_4000, 0);
            else set_tiles(0, 0, 0, 0);
            if (c == 12) begin
                chk("t6_next_out_a", u4_next_out, 1);
                chk_tile("t6_out_pre", u4_out, 32'h0, 32'h0);
            end
            if (c == 13) chk_tile("t6_out_a", u4_out, 32'h000C_0000, 32'h0);
            if (c == 14) chk("t6_busy_between", u4_busy, 1);
            if (c == 20) chk_tile("t6_out_stable", u4_out, 32'h000C_0000, 32'h0);
            if (c == 22) chk("t6_next_out_quiet", u4_next_out, 0);
            if (c == 24) begin
                chk("t6_next_out_b", u4_next_out, 1);
                chk("t6_busy_last", u4_busy, 1);
            end
            if (c == 25) begin
                chk_tile("t6_out_b", u4_out, 32'h0001_0000, 32'h0);
                chk("t6_busy_done", u4_busy, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
